mux_arbiter: RTL

//  Two-requester round-robin arbiter that shares one 2:1 mux output path (out = sel ? b : a).

---
 rtl/mux_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/mux_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mux_arbiter
//  Description : Two-requester round-robin arbiter owning the select of a
//                shared 2:1 data mux (data_out = sel ? data_b : data_a).
//                The grant FSM is registered. MAX_HOLD limits the tenure of
//                one side while the other waits.
//                Optional grant statistics are enabled by the macro
//                MUX_ARB_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_arbiter #(
  parameter int WIDTH    = 1,
  parameter int MAX_HOLD = 8
`ifdef MUX_ARB_STATS_EN
  , parameter int CNT_W  = 16
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             sel,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out
`ifdef MUX_ARB_STATS_EN
  , output logic [CNT_W-1:0] gcnt_a
  , output logic [CNT_W-1:0] gcnt_b
`endif
);

  // The hold counter only has to reach MAX_HOLD-1.
  localparam int              HC_W     = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HC_W-1:0] HOLD_LIM = (MAX_HOLD > 0) ? HC_W'(MAX_HOLD - 1) : '0;
  localparam bit              HOLD_EN  = (MAX_HOLD != 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GNT_A = 2'd1,
    S_GNT_B = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [HC_W-1:0] hold_cnt_q, hold_cnt_d;
  logic            last_b_q, last_b_d;   // 1: the most recent grant went to B
  logic            sel_q, sel_d;
  logic            gnt_a_q, gnt_b_q;
  logic            hold_sat;

  assign hold_sat = (hold_cnt_q == HOLD_LIM);

  // Next-state decision: arbitration, release, preemption and hold counting.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    last_b_d   = last_b_q;
    sel_d      = sel_q;

    case (state_q)
      S_IDLE: begin
        if (req_a && req_b) begin
          state_d = last_b_q ? S_GNT_A : S_GNT_B;
        end else if (req_a) begin
          state_d = S_GNT_A;
        end else if (req_b) begin
          state_d = S_GNT_B;
        end
      end
      S_GNT_A: begin
        if (!req_a) begin
          state_d = req_b ? S_GNT_B : S_IDLE;
        end else if (HOLD_EN && hold_sat && req_b) begin
          state_d = S_GNT_B;
        end
      end
      S_GNT_B: begin
        if (!req_b) begin
          state_d = req_a ? S_GNT_A : S_IDLE;
        end else if (HOLD_EN && hold_sat && req_a) begin
          state_d = S_GNT_A;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A new owner restarts its tenure and moves the mux in the same edge.
    if (state_d != state_q) begin
      hold_cnt_d = '0;
      if (state_d == S_GNT_A) begin
        last_b_d = 1'b0;
        sel_d    = 1'b0;
      end else if (state_d == S_GNT_B) begin
        last_b_d = 1'b1;
        sel_d    = 1'b1;
      end
    end else if ((state_q != S_IDLE) && !hold_sat) begin
      hold_cnt_d = hold_cnt_q + 1'b1;
    end
  end

  // Grant FSM registers; grants and select clear asynchronously on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      hold_cnt_q <= '0;
      last_b_q   <= 1'b1;
      sel_q      <= 1'b0;
      gnt_a_q    <= 1'b0;
      gnt_b_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      last_b_q   <= last_b_d;
      sel_q      <= sel_d;
      gnt_a_q    <= (state_d == S_GNT_A);
      gnt_b_q    <= (state_d == S_GNT_B);
    end
  end

  assign gnt_a     = gnt_a_q;
  assign gnt_b     = gnt_b_q;
  assign sel       = sel_q;
  assign data_out  = sel_q ? data_b : data_a;
  assign valid_out = (gnt_a_q & req_a) | (gnt_b_q & req_b);

`ifdef MUX_ARB_STATS_EN
  logic [CNT_W-1:0] gcnt_a_q, gcnt_b_q;
  logic             enter_a, enter_b;

  assign enter_a = (state_d == S_GNT_A) && (state_q != S_GNT_A);
  assign enter_b = (state_d == S_GNT_B) && (state_q != S_GNT_B);

  // Saturating count of entries into each grant state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gcnt_a_q <= '0;
      gcnt_b_q <= '0;
    end else begin
      if (enter_a && (gcnt_a_q != '1)) begin
        gcnt_a_q <= gcnt_a_q + 1'b1;
      end
      if (enter_b && (gcnt_b_q != '1)) begin
        gcnt_b_q <= gcnt_b_q + 1'b1;
      end
    end
  end

  assign gcnt_a = gcnt_a_q;
  assign gcnt_b = gcnt_b_q;
`endif

endmodule
`default_nettype wire
